// File: rtl/bp_cce_mem_cmd_gate.sv
// bp_cce_mem_cmd_gate: buffers CCE memory commands toward the memory network, caps
// outstanding commands with a credit counter, buffers responses back, and supports a flush drain.
// Latency: 1 cycle cmd in -> mem_cmd_v_o, 1 cycle mem_resp in -> cce_mem_resp_v_o (no bypass).
// Backpressure: cmd intake closes when the cmd FIFO is full or a drain is active; issue stalls at max credits.
//
// Ports:
//   clk_i / reset_n_i                         clock, async active-low reset
//   cce_mem_cmd_{i,v_i,ready_o}               command from CCE (ready->valid)
//   mem_cmd_{o,v_o,ready_i}                   command to memory (valid->ready)
//   mem_resp_{i,v_i,ready_o}                  response from memory
//   cce_mem_resp_{o,v_o,yumi_i}               response to CCE (valid->yumi)
//   flush_i / flush_done_o                    drain request level / completion pulse
//   credits_used_o / err_o                    outstanding cmd count / sticky underflow error

// Small circular FIFO shared by the command queue and the response buffer.
// Latency: data written on an enqueue edge is at the head the following cycle.
// Backpressure: enqueue ignored when full, dequeue ignored when empty.
module bp_cce_mem_cmd_gate_fifo #(
    parameter int width_p = 128,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               enq_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                do_enq, do_deq;

    assign full_o  = (cnt_r == cnt_w_lp'(els_p));
    assign empty_o = (cnt_r == '0);
    assign do_enq  = enq_i & ~full_o;
    // An empty FIFO never dequeues, so a same-cycle enqueue is not bypassed.
    assign do_deq  = deq_i & ~empty_o;
    assign data_o  = mem_r[rptr_r];

    // Pointers wrap at the depth so non-power-of-two depths work.
    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (do_enq) wptr_r <= next_ptr(wptr_r);
            if (do_deq) rptr_r <= next_ptr(rptr_r);
            if (do_enq & ~do_deq)      cnt_r <= cnt_r + cnt_w_lp'(1);
            else if (do_deq & ~do_enq) cnt_r <= cnt_r - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_enq) mem_r[wptr_r] <= data_i;
    end
endmodule

module bp_cce_mem_cmd_gate #(
    parameter int msg_width_p   = 128,
    parameter int cmd_els_p     = 2,
    parameter int max_credits_p = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [msg_width_p-1:0]             cce_mem_cmd_i,
    input  logic                               cce_mem_cmd_v_i,
    output logic                               cce_mem_cmd_ready_o,
    output logic [msg_width_p-1:0]             mem_cmd_o,
    output logic                               mem_cmd_v_o,
    input  logic                               mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]             mem_resp_i,
    input  logic                               mem_resp_v_i,
    output logic                               mem_resp_ready_o,
    output logic [msg_width_p-1:0]             cce_mem_resp_o,
    output logic                               cce_mem_resp_v_o,
    input  logic                               cce_mem_resp_yumi_i,
    input  logic                               flush_i,
    output logic                               flush_done_o,
    output logic [$clog2(max_credits_p+1)-1:0] credits_used_o,
    output logic                               err_o
);
    localparam int cw_lp = $clog2(max_credits_p + 1);

    typedef enum logic [1:0] {e_run, e_drain, e_done} state_e;
    state_e state_r, state_n;

    logic             cmd_full, cmd_empty, resp_full, resp_empty;
    logic             cmd_enq, issue, resp_enq, consume, idle;
    logic [cw_lp-1:0] credits_r;
    logic             err_r;

    // Readies are gated by reset so nothing is accepted while reset is held.
    assign cce_mem_cmd_ready_o = reset_n_i & ~cmd_full & (state_r == e_run);
    assign cmd_enq             = cce_mem_cmd_v_i & cce_mem_cmd_ready_o;
    assign mem_cmd_v_o         = ~cmd_empty & (credits_r < cw_lp'(max_credits_p));
    assign issue               = mem_cmd_v_o & mem_cmd_ready_i;

    assign mem_resp_ready_o    = reset_n_i & ~resp_full;
    assign resp_enq            = mem_resp_v_i & mem_resp_ready_o;
    assign cce_mem_resp_v_o    = ~resp_empty;
    assign consume             = cce_mem_resp_v_o & cce_mem_resp_yumi_i;

    assign credits_used_o      = credits_r;
    assign err_o               = err_r;
    assign idle                = cmd_empty & resp_empty & (credits_r == '0);

    bp_cce_mem_cmd_gate_fifo #(.width_p(msg_width_p), .els_p(cmd_els_p)) cmd_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (cce_mem_cmd_i),
        .enq_i    (cmd_enq),
        .deq_i    (issue),
        .data_o   (mem_cmd_o),
        .full_o   (cmd_full),
        .empty_o  (cmd_empty)
    );

    bp_cce_mem_cmd_gate_fifo #(.width_p(msg_width_p), .els_p(2)) resp_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (mem_resp_i),
        .enq_i    (resp_enq),
        .deq_i    (consume),
        .data_o   (cce_mem_resp_o),
        .full_o   (resp_full),
        .empty_o  (resp_empty)
    );

    // Issue and consume in the same cycle cancel out. A consume with nothing
    // outstanding is a protocol error: the count saturates at zero and err latches.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (issue & ~consume)
                credits_r <= credits_r + cw_lp'(1);
            else if (consume & ~issue & (credits_r != '0))
                credits_r <= credits_r - cw_lp'(1);
            if (consume & (credits_r == '0))
                err_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_run;
        else            state_r <= state_n;
    end

    // DONE always lasts exactly one cycle, which is the flush_done pulse.
    always_comb begin
        state_n      = state_r;
        flush_done_o = 1'b0;
        unique case (state_r)
            e_run:   if (flush_i) state_n = e_drain;
            e_drain: if (idle)    state_n = e_done;
            e_done: begin
                flush_done_o = 1'b1;
                state_n      = e_run;
            end
            default: state_n = e_run;
        endcase
    end
endmodule
